// File: rtl/bin_bcd_pkg.sv
// Shared definitions for the binary/BCD converter pair: FSM state encodings,
// digit width, add-3 threshold and a constant power-of-ten helper used for
// elaboration-time range checks.
package bin_bcd_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'b000,
    ST_ADD   = 3'b001,
    ST_SHIFT = 3'b010,
    ST_END1  = 3'b011,
    ST_ITER  = 3'b100
  } state_t;

  localparam int          DIGIT_W     = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;

  // 10**n as a 64-bit constant; valid for n <= 19.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_control.sv
// Control FSM for bin_to_bcd: sequences load, add-3 correction, shift and
// result publication. done/busy are registered Moore outputs.
// Backpressure: none; init is only sampled in START, so requests made while
// busy are dropped.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   init         start request
//   last         datapath counter is on its final bit
//   ld           load operand (START with init)
//   w_add        apply add-3 correction this cycle
//   w_sh         shift the register this cycle
//   dec          decrement the bit counter this cycle
//   done, busy   status outputs
// Macro BIN_TO_BCD_FAST_EN: when defined, correction and shift share one ITER
// state per bit instead of alternating ADD/SHIFT states.
module control_bin_to_bcd
  import bin_bcd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic last,
  output logic ld,
  output logic w_add,
  output logic w_sh,
  output logic dec,
  output logic done,
  output logic busy
);

  state_t r_state;
  logic   r_done;
  logic   r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_START;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          if (init) begin
`ifdef BIN_TO_BCD_FAST_EN
            r_state <= ST_ITER;
`else
            r_state <= ST_ADD;
`endif
            r_busy  <= 1'b1;
          end
        end
        ST_ADD: begin
          r_state <= ST_SHIFT;
        end
        ST_SHIFT, ST_ITER: begin
          if (last) begin
            r_state <= ST_END1;
            r_done  <= 1'b1;
          end else begin
`ifdef BIN_TO_BCD_FAST_EN
            r_state <= ST_ITER;
`else
            r_state <= ST_ADD;
`endif
          end
        end
        ST_END1: begin
          r_state <= ST_START;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_START;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath strobes decoded from the current state; ITER asserts both the
  // correction and the shift so the datapath chains them in one cycle.
  assign ld    = (r_state == ST_START) && init;
  assign w_add = (r_state == ST_ADD)   || (r_state == ST_ITER);
  assign w_sh  = (r_state == ST_SHIFT) || (r_state == ST_ITER);
  assign dec   = w_sh;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
// Latency: init accepted at edge E0, done high in the cycle after E0+2*N_BITS
// (E0+N_BITS with BIN_TO_BCD_FAST_EN), bcd_out updated on the following edge.
// Backpressure: one conversion at a time; init while busy is ignored.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   init       start request, sampled only when idle
//   bin_in     binary operand, captured when init is accepted
//   bcd_out    packed BCD result, digit 0 in [3:0], held until next result
//   done       one-cycle result pulse
//   busy       conversion in progress
// Macro BIN_TO_BCD_FAST_EN: merges correction and shift into one cycle per bit.
module bin_to_bcd
  import bin_bcd_pkg::*;
#(
  parameter int N_BITS   = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init,
  input  logic [N_BITS-1:0]             bin_in,
  output logic [DIGIT_W*N_DIGITS-1:0]   bcd_out,
  output logic                          done,
  output logic                          busy
);

  localparam int BCD_W = DIGIT_W * N_DIGITS;
  localparam int SR_W  = BCD_W + N_BITS;
  localparam int CNT_W = $clog2(N_BITS + 1);

  localparam logic [63:0] MAX_BIN = (64'd1 << N_BITS) - 64'd1;
  localparam logic [63:0] P10     = pow10(N_DIGITS);

  // Too few digits would silently truncate the largest operands.
  generate
    if (P10 <= MAX_BIN) begin : g_range_chk
      $fatal(1, "bin_to_bcd: N_DIGITS too small for N_BITS");
    end
  endgenerate

  logic [SR_W-1:0]  r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_bcd;
  logic [SR_W-1:0]  w_corr;
  logic             w_ld;
  logic             w_add;
  logic             w_sh;
  logic             w_dec;
  logic             w_last;

  control_bin_to_bcd u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .init  (init),
    .last  (w_last),
    .ld    (w_ld),
    .w_add (w_add),
    .w_sh  (w_sh),
    .dec   (w_dec),
    .done  (done),
    .busy  (busy)
  );

  // Binary part passes through; each BCD nibble is corrected in parallel.
  // A nibble is at most 9 before correction, so +3 never overflows 4 bits.
  assign w_corr[N_BITS-1:0] = r_sr[N_BITS-1:0];

  generate
    for (genvar d = 0; d < N_DIGITS; d++) begin : g_add3
      logic [DIGIT_W-1:0] w_nib;
      assign w_nib = r_sr[N_BITS + d*DIGIT_W +: DIGIT_W];
      assign w_corr[N_BITS + d*DIGIT_W +: DIGIT_W] =
        (w_add && (w_nib >= ADD3_THRESH)) ? (w_nib + 4'd3) : w_nib;
    end
  endgenerate

  assign w_last = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_bcd <= '0;
    end else begin
      if (w_ld) begin
        r_sr  <= {{BCD_W{1'b0}}, bin_in};
        r_cnt <= CNT_W'(N_BITS);
      end else if (w_sh) begin
        // In ITER w_corr already carries the correction, so this is add+shift.
        r_sr <= {w_corr[SR_W-2:0], 1'b0};
      end else if (w_add) begin
        r_sr <= w_corr;
      end
      if (w_dec) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // done is high exactly during END1; publish on the edge leaving it.
      if (done) begin
        r_bcd <= r_sr[SR_W-1 -: BCD_W];
      end
    end
  end

  assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd.sv
module tb_bin_to_bcd;

  localparam int NB = 16;
  localparam int ND = 5;
`ifdef BIN_TO_BCD_FAST_EN
  localparam int LAT = NB;
`else
  localparam int LAT = 2 * NB;
`endif
  localparam int PERIOD = LAT + 2;

  logic          clk;
  logic          rst;
  logic          init;
  logic [NB-1:0] bin_in;
  logic [4*ND-1:0] bcd_out;
  logic          done;
  logic          busy;

  bin_to_bcd #(.N_BITS(NB), .N_DIGITS(ND)) dut (
    .clk     (clk),
    .rst     (rst),
    .init    (init),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NB-1:0]   bin;
    logic [4*ND-1:0] bcd;
    int              e0;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  bit   chk_pending = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  // Reference: decimal digits by plain division.
  function automatic logic [4*ND-1:0] ref_bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < ND; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      chk_pending = 0;
      sb.delete();
    end else begin
      if (chk_pending) begin
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("bcd_out", {12'd0, bcd_out}, {12'd0, pend.bcd});
        chk_pending = 0;
      end
      if (done) begin
        done_cnt++;
        chk("busy_during_done", {31'd0, busy}, 32'd1);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stray_done actual=done required=no_done (cycle %0d)", cyc);
        end else begin
          pend = sb.pop_front();
          chk("done_latency", cyc, pend.e0 + LAT);
          chk_pending = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic start_conv(input logic [NB-1:0] v);
    exp_t e;
    wait_idle();
    init   = 1'b1;
    bin_in = v;
    e.bin  = v;
    e.bcd  = ref_bcd(int'(v));
    e.e0   = cyc + 1;
    sb.push_back(e);
    step();
    init   = 1'b0;
    bin_in = NB'($urandom);  // must not disturb the running conversion
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || chk_pending || busy) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=pending required=empty");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    exp_t e;
    rst    = 1'b1;
    init   = 1'b0;
    bin_in = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_bcd_out", {12'd0, bcd_out}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Directed operands, including zero and full scale.
    start_conv(16'd0);
    start_conv(16'd65535);
    start_conv(16'd1234);
    start_conv(16'd9);
    drain();

    // A second init mid-conversion is dropped.
    d0 = done_cnt;
    start_conv(16'd7777);
    repeat (4) step();
    init   = 1'b1;
    bin_in = 16'd42;
    step();
    init   = 1'b0;
    drain();
    repeat (PERIOD) step();
    chk("ignored_init_done_count", done_cnt - d0, 32'd1);

    // Reset in the middle of a conversion aborts it.
    d0 = done_cnt;
    start_conv(16'd500);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_bcd_out", {12'd0, bcd_out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    repeat (PERIOD) step();
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    start_conv(16'd500);
    drain();

    // init held high: back-to-back conversions, one per PERIOD cycles.
    wait_idle();
    init = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bin_in = NB'(100 + k);
      e.bin  = bin_in;
      e.bcd  = ref_bcd(100 + k);
      e.e0   = cyc + 1;
      sb.push_back(e);
      step();
      if (k < 2) repeat (PERIOD - 1) step();
    end
    init = 1'b0;
    drain();

    // Randomized operands with random idle gaps.
    for (int i = 0; i < 300; i++) begin
      start_conv(NB'($urandom_range(0, 65535)));
      repeat ($urandom_range(0, 3)) step();
    end
    drain();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
